// File: rtl/xif_coproc_pkg.sv
// Shared definitions for the XIF custom-instruction ALU coprocessor.
// The op encoding is funct3; the result record is what the core sees on the result port.
package xif_coproc_pkg;

   localparam logic [6:0]  OPCODE_XIF = 7'h5B;
   localparam int unsigned XIF_XLEN   = 32;
   localparam int unsigned XIF_ID_W   = 4;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_MIN   = 3'b010,
      OP_MAX   = 3'b011,
      OP_ACC   = 3'b100,
      OP_ACCRD = 3'b101
   } op_e;

   // Default-width result record; the top re-declares it at its own XLEN/ID_W.
   typedef struct packed {
      logic [XIF_ID_W-1:0] id;
      logic [4:0]          rd;
      logic [XIF_XLEN-1:0] data;
   } xif_result_t;

endpackage

// File: rtl/xif_result_fifo.sv
// Synchronous result FIFO with extra-MSB pointers; full/empty come from the MSB compare.
// Simultaneous push and pop on a full FIFO is legal and leaves the count unchanged.
module xif_result_fifo
   import xif_coproc_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = xif_result_t,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  entry_t       wdata_i,
   input  logic         pop_i,
   output entry_t       rdata_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [PTR_W:0] count_o
);

   logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
   entry_t         mem_q [DEPTH];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // NOTE: storage is not reset; the read port is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
   end

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/xif_alu_coproc.sv
// XIF custom-instruction coprocessor: decode, ALU/accumulator, fixed-latency pipe and result FIFO.
// Issue credits count pipe entries plus FIFO entries so the non-stalling pipe never overflows the FIFO.
module xif_alu_coproc
   import xif_coproc_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ID_W       = 4,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [6:0]  OPCODE     = OPCODE_XIF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   output logic            issue_accept_o,
   input  logic [31:0]     issue_instr_i,
   input  logic [XLEN-1:0] issue_opa_i,
   input  logic [XLEN-1:0] issue_opb_i,
   input  logic [ID_W-1:0] issue_id_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [ID_W-1:0] result_id_o,
   output logic [4:0]      result_rd_o,
   output logic [XLEN-1:0] result_data_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } res_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   op_e        op;
   logic       fire, pop;
   logic       unused_rs_fields;

   assign opcode = issue_instr_i[6:0];
   assign funct3 = issue_instr_i[14:12];
   assign funct7 = issue_instr_i[31:25];
   assign op     = op_e'(funct3);
   assign unused_rs_fields = ^issue_instr_i[24:15];

   assign issue_accept_o = (opcode == OPCODE) && (funct7 == 7'd0) && (funct3 <= 3'b101);
   assign fire           = issue_valid_i && issue_ready_o && issue_accept_o;

   logic [XLEN-1:0] acc_q, acc_d, alu_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      alu_data = '0;
      acc_d    = acc_q;
      if (fire) begin
         case (op)
            OP_ADD:   alu_data = issue_opa_i + issue_opb_i;
            OP_SUB:   alu_data = issue_opa_i - issue_opb_i;
            OP_MIN:   alu_data = ($signed(issue_opa_i) < $signed(issue_opb_i)) ? issue_opa_i : issue_opb_i;
            OP_MAX:   alu_data = ($signed(issue_opa_i) > $signed(issue_opb_i)) ? issue_opa_i : issue_opb_i;
            OP_ACC: begin
               acc_d    = acc_q + issue_opa_i;
               alu_data = acc_d;
            end
            OP_ACCRD: begin
               alu_data = acc_q;
               acc_d    = '0;
            end
            default: ;
         endcase
      end
   end

   logic [LATENCY-1:0] pipe_valid_q;
   res_t               pipe_q [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         pipe_valid_q <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         acc_q           <= acc_d;
         pipe_valid_q[0] <= fire;
         if (fire) pipe_q[0] <= '{id: issue_id_i, rd: issue_instr_i[11:7], data: alu_data};
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_q[i]       <= pipe_q[i-1];
         end
      end
   end

   res_t           head;
   logic           fifo_empty;
   logic           unused_fifo_full;
   logic [PTR_W:0] fifo_count;

   xif_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (res_t)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (pipe_valid_q[LATENCY-1]),
      .wdata_i (pipe_q[LATENCY-1]),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (unused_fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign result_valid_o = !fifo_empty;
   assign pop            = result_valid_o && result_ready_i;
   assign result_id_o    = head.id;
   assign result_rd_o    = head.rd;
   assign result_data_o  = head.data;

   // A pop this cycle frees a slot, so it may be re-granted immediately.
   logic [CNT_W-1:0] inflight;
   always_comb begin
      inflight = CNT_W'(fifo_count);
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CNT_W'(pipe_valid_q[i]);
   end

   assign issue_ready_o = (inflight < CNT_W'(FIFO_DEPTH)) || pop;

endmodule

// File: tb/tb_xif_alu_coproc.sv
// Bench for xif_alu_coproc: a vector table plus hand sequences, with a scoreboard queue
// filled at issue time and drained by a monitor on every result pop.
module tb_xif_alu_coproc;

   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_ready, issue_accept;
   logic [31:0] issue_instr, issue_opa, issue_opb;
   logic [3:0]  issue_id;
   logic        result_valid, result_ready;
   logic [3:0]  result_id;
   logic [4:0]  result_rd;
   logic [31:0] result_data;

   xif_alu_coproc #(
      .XLEN(32), .ID_W(4), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH), .OPCODE(7'h5B)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .issue_valid_i  (issue_valid),
      .issue_ready_o  (issue_ready),
      .issue_accept_o (issue_accept),
      .issue_instr_i  (issue_instr),
      .issue_opa_i    (issue_opa),
      .issue_opb_i    (issue_opb),
      .issue_id_i     (issue_id),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
      .result_id_o    (result_id),
      .result_rd_o    (result_rd),
      .result_data_o  (result_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, rd, opc};
   endfunction

   // Scoreboard monitor: every pop must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(result_id), 64'hFFFF);
         end else begin
            check("res_id",   64'(result_id),   64'(exp_q[0].id));
            check("res_rd",   64'(result_rd),   64'(exp_q[0].rd));
            check("res_data", 64'(result_data), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
         end
      end
   end

   // Entered and left at posedge+1; offers one instruction until it fires.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] id, input logic [4:0] rd, input bit sb,
                        input logic [31:0] exp);
      int waited = 0;
      issue_valid = 1'b1;
      issue_instr = mk_instr(7'd0, f3, rd, 7'h5B);
      issue_opa   = a;
      issue_opb   = b;
      issue_id    = id;
      @(negedge clk);
      while (!issue_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check("issue_timeout", 64'(issue_ready), 64'd1);
      if (sb) exp_q.push_back('{id: id, rd: rd, data: exp});
      @(posedge clk);
      #1 issue_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[10];
   int   fires;

   initial begin
      vecs[0] = '{3'b000, 32'd5,          32'd7,          4'd3,  5'd10, 32'd12};
      vecs[1] = '{3'b001, 32'd0,          32'd1,          4'd4,  5'd11, 32'hFFFF_FFFF};
      vecs[2] = '{3'b010, 32'hFFFF_FFFF,  32'd1,          4'd5,  5'd12, 32'hFFFF_FFFF};
      vecs[3] = '{3'b011, 32'hFFFF_FFFF,  32'd1,          4'd6,  5'd13, 32'd1};
      vecs[4] = '{3'b000, 32'hFFFF_FFFF,  32'd2,          4'd7,  5'd14, 32'd1};
      vecs[5] = '{3'b010, 32'h7FFF_FFFF,  32'h8000_0000,  4'd8,  5'd15, 32'h8000_0000};
      vecs[6] = '{3'b100, 32'd10,         32'd99,         4'd9,  5'd16, 32'd10};
      vecs[7] = '{3'b100, 32'd20,         32'd99,         4'd10, 5'd17, 32'd30};
      vecs[8] = '{3'b101, 32'd0,          32'd0,          4'd11, 5'd18, 32'd30};
      vecs[9] = '{3'b100, 32'd1,          32'd0,          4'd12, 5'd19, 32'd1};

      reset        = 1'b1;
      issue_valid  = 1'b0;
      issue_instr  = '0;
      issue_opa    = '0;
      issue_opb    = '0;
      issue_id     = '0;
      result_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_issue_ready",  64'(issue_ready),  64'd1);
      check("rst_result_id",    64'(result_id),    64'd0);
      check("rst_result_rd",    64'(result_rd),    64'd0);
      check("rst_result_data",  64'(result_data),  64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Latency: fire edge, then two idle cycles, valid on the third.
      issue(3'b000, 32'd5, 32'd7, 4'd3, 5'd10, 1'b1, 32'd12);
      @(negedge clk);
      check("lat_n1_valid", 64'(result_valid), 64'd0);
      @(negedge clk);
      check("lat_n2_valid", 64'(result_valid), 64'd0);
      @(negedge clk);
      check("lat_n3_valid", 64'(result_valid), 64'd1);
      drain();

      for (int i = 0; i < 10; i++)
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].rd, 1'b1, vecs[i].exp);
      drain();

      // Rejected encodings: no accept, no result, accumulator untouched.
      issue_valid = 1'b1;
      issue_opa   = 32'd100;
      issue_instr = mk_instr(7'd0, 3'b100, 5'd1, 7'h0B);
      @(negedge clk);
      check("rej_opcode_accept", 64'(issue_accept), 64'd0);
      @(posedge clk);
      #1 issue_instr = mk_instr(7'd1, 3'b100, 5'd1, 7'h5B);
      @(negedge clk);
      check("rej_funct7_accept", 64'(issue_accept), 64'd0);
      @(posedge clk);
      #1 issue_instr = mk_instr(7'd0, 3'b110, 5'd1, 7'h5B);
      @(negedge clk);
      check("rej_funct3_accept", 64'(issue_accept), 64'd0);
      @(posedge clk);
      #1 issue_instr = mk_instr(7'd0, 3'b101, 5'd1, 7'h5B);
      issue_valid = 1'b0;
      @(negedge clk);
      check("good_accept", 64'(issue_accept), 64'd1);
      repeat (4) @(negedge clk);
      check("rej_no_result", 64'(result_valid), 64'd0);
      @(posedge clk);
      #1;
      issue(3'b101, 32'd0, 32'd0, 4'd1, 5'd20, 1'b1, 32'd1);
      drain();

      // Back-pressure: only DEPTH of six offered ADDs may fire.
      result_ready = 1'b0;
      fires = 0;
      for (int i = 0; i < 6; i++) begin
         issue_valid = 1'b1;
         issue_instr = mk_instr(7'd0, 3'b000, 5'd3, 7'h5B);
         issue_opa   = 32'(fires + 1);
         issue_opb   = 32'd100;
         issue_id    = 4'(fires);
         @(negedge clk);
         if (issue_ready) begin
            exp_q.push_back('{id: 4'(fires), rd: 5'd3, data: 32'(fires + 101)});
            fires++;
         end
         @(posedge clk);
         #1;
      end
      issue_valid = 1'b0;
      @(negedge clk);
      check("bp_fire_count",  64'(fires),       64'(DEPTH));
      check("bp_issue_ready", 64'(issue_ready), 64'd0);
      check("bp_hold_valid",  64'(result_valid), 64'd1);
      check("bp_hold_id",     64'(result_id),   64'(exp_q[0].id));
      @(negedge clk);
      check("bp_hold_data",   64'(result_data), 64'(exp_q[0].data));
      @(posedge clk);
      #1 result_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_on_pop", 64'(issue_ready), 64'd1);
      drain();

      // Reset with one result queued and two still in the pipe.
      result_ready = 1'b0;
      issue(3'b100, 32'd5, 32'd0, 4'd1, 5'd4, 1'b0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      issue(3'b100, 32'd6, 32'd0, 4'd2, 5'd5, 1'b0, 32'd0);
      issue(3'b100, 32'd7, 32'd0, 4'd3, 5'd6, 1'b0, 32'd0);
      reset       = 1'b1;
      issue_instr = mk_instr(7'd0, 3'b101, 5'd7, 7'h5B);
      @(negedge clk);
      check("rst_mid_accept", 64'(issue_accept), 64'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", 64'(result_valid), 64'd0);
      check("rst_mid_ready", 64'(issue_ready),  64'd1);
      check("rst_mid_data",  64'(result_data),  64'd0);
      @(posedge clk);
      #1 result_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      issue(3'b101, 32'd0, 32'd0, 4'd9, 5'd8, 1'b1, 32'd0);
      drain();

      repeat (4) @(negedge clk);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
